// File: rtl/axi4_pkg.sv
// Purpose : shared AXI4 types, widths and response decode for the memory responder slice.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: resp_t, burst_t, rd_state_t, wr_state_t, bus widths, SIZE_8B, decode_resp().
package axi4_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int ID_W   = 6;
    localparam int LEN_W  = 4;

    // Only full 64-bit beats are served.
    localparam logic [2:0] SIZE_8B = 3'b011;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_WAIT,
        W_RESP
    } wr_state_t;

    // Burst-wide response decided at the address handshake. An injected
    // error wins over everything; an out-of-range start address wins over
    // unsupported burst/size. WRAP and the reserved burst code are SLVERR.
    function automatic resp_t decode_resp(input logic       in_range,
                                          input logic       inject,
                                          input logic [1:0] burst,
                                          input logic [2:0] size);
        if (inject)
            return SLVERR;
        if (!in_range)
            return DECERR;
        if ((burst != FIXED && burst != INCR) || size != SIZE_8B)
            return SLVERR;
        return OKAY;
    endfunction

endpackage

// File: rtl/axi4_if.sv
// Purpose : AXI4 bundle (32b addr, 64b data, 8b strb, 6b id, 4b len) shared by initiators and targets.
// Latency : n/a (wires only).
// Backpr. : standard AXI valid/ready on each of AW, W, B, AR, R.
// Modports: slave_mp (target side), master_mp (initiator side).
interface axi4_if;
    import axi4_pkg::*;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave_mp (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master_mp (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/axi4_mem_array.sv
// Purpose : DEPTH_WORDS x 64-bit flop memory, byte-strobed write port, combinational read port.
// Latency : write lands on the next Clk edge; read is same-cycle, so a same-cycle write is not visible.
// Backpr. : none; always accepts.
// Ports   : Clk, wr_en/wr_idx/wr_dat/wr_strb (write), rd_idx/rd_dat (read). Contents are never reset.
module axi4_mem_array
    import axi4_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           Clk,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [DATA_W-1:0]              wr_dat,
    input  logic [STRB_W-1:0]              wr_strb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [DATA_W-1:0]              rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b])
                    mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
            end
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/axi4_mem_responder.sv
// Purpose : AXI4 target serving read/write bursts from an internal flop memory; one burst outstanding per direction.
// Latency : first R beat RD_LATENCY+1 cycles after AR; B presented WR_RESP_LATENCY+1 cycles after last W beat.
// Backpr. : R beats/B hold stable until rready/bready; AR/AW stall while a burst is active; wready only in W_DATA.
// Ports   : Clk, Rst (async active-high), s_axi4_if (slave_mp), rd_done (R last handshake), wr_done (B handshake).
// Option  : AXI4_RESP_ERR_INJECT_EN adds err_inject (forces SLVERR on the burst) and err_inject_cnt (saturating).
module axi4_mem_responder
    import axi4_pkg::*;
#(
    parameter int          DEPTH_WORDS     = 1024,
    parameter int          RD_LATENCY      = 0,
    parameter int          WR_RESP_LATENCY = 0,
    parameter logic [31:0] BASE_ADDR       = 32'h0
) (
    input  logic        Clk,
    input  logic        Rst,
    axi4_if.slave_mp    s_axi4_if,
`ifdef AXI4_RESP_ERR_INJECT_EN
    input  logic        err_inject,
    output logic [15:0] err_inject_cnt,
`endif
    output logic        rd_done,
    output logic        wr_done
);

    localparam int                IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0]   RANGE_BYTES = (ADDR_W+1)'(DEPTH_WORDS) * (ADDR_W+1)'(8);
    localparam logic [15:0]       RD_LAT_LAST = 16'(RD_LATENCY - 1);
    localparam logic [15:0]       WR_LAT_LAST = 16'(WR_RESP_LATENCY - 1);

    logic inject_in;
`ifdef AXI4_RESP_ERR_INJECT_EN
    assign inject_in = err_inject;
`else
    assign inject_in = 1'b0;
`endif

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0] ar_off, aw_off;
    logic              ar_in_range, aw_in_range;
    resp_t             ar_resp_dec, aw_resp_dec;

    assign ar_off      = s_axi4_if.araddr - BASE_ADDR;
    assign aw_off      = s_axi4_if.awaddr - BASE_ADDR;
    assign ar_in_range = (s_axi4_if.araddr >= BASE_ADDR) && ({1'b0, ar_off} < RANGE_BYTES);
    assign aw_in_range = (s_axi4_if.awaddr >= BASE_ADDR) && ({1'b0, aw_off} < RANGE_BYTES);
    assign ar_resp_dec = decode_resp(ar_in_range, inject_in, s_axi4_if.arburst, s_axi4_if.arsize);
    assign aw_resp_dec = decode_resp(aw_in_range, inject_in, s_axi4_if.awburst, s_axi4_if.awsize);

    // ---------------- read channel ----------------
    rd_state_t         rd_state_q, rd_state_d;
    logic [ID_W-1:0]   rd_id_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [LEN_W-1:0]  rd_len_q, rd_beat_q;
    logic              rd_fixed_q;
    resp_t             rd_resp_q;
    logic [15:0]       rd_lat_q;
    logic [DATA_W-1:0] mem_rd_dat;

    logic              arready_c, rvalid_c, rlast_c, ar_hs, r_hs;
    logic [ID_W-1:0]   rid_c;
    logic [DATA_W-1:0] rdata_c;
    resp_t             rresp_c;

    assign ar_hs = s_axi4_if.arvalid && arready_c;
    assign r_hs  = rvalid_c && s_axi4_if.rready;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            rd_state_q <= R_IDLE;
        else
            rd_state_q <= rd_state_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_c  = 1'b0;
        rvalid_c   = 1'b0;
        rlast_c    = 1'b0;
        rid_c      = '0;
        rresp_c    = OKAY;
        rdata_c    = '0;
        case (rd_state_q)
            R_IDLE: begin
                // Gate with Rst so arready is low throughout reset.
                arready_c = !Rst;
                if (ar_hs)
                    rd_state_d = (RD_LATENCY > 0) ? R_WAIT : R_DATA;
            end
            R_WAIT: begin
                if (rd_lat_q == RD_LAT_LAST)
                    rd_state_d = R_DATA;
            end
            R_DATA: begin
                rvalid_c = 1'b1;
                rlast_c  = (rd_beat_q == rd_len_q);
                rid_c    = rd_id_q;
                rresp_c  = rd_resp_q;
                rdata_c  = (rd_resp_q == OKAY) ? mem_rd_dat : '0;
                if (r_hs && rlast_c)
                    rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_id_q    <= '0;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_fixed_q <= 1'b0;
            rd_resp_q  <= OKAY;
            rd_lat_q   <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_id_q    <= s_axi4_if.arid;
                        rd_idx_q   <= ar_off[3 +: IDX_W];
                        rd_len_q   <= s_axi4_if.arlen;
                        rd_fixed_q <= (s_axi4_if.arburst == FIXED);
                        rd_resp_q  <= ar_resp_dec;
                        rd_beat_q  <= '0;
                        rd_lat_q   <= '0;
                    end
                end
                R_WAIT: rd_lat_q <= rd_lat_q + 16'd1;
                R_DATA: begin
                    if (r_hs && !rlast_c) begin
                        rd_beat_q <= rd_beat_q + 1'b1;
                        if (!rd_fixed_q)
                            rd_idx_q <= rd_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write channel ----------------
    wr_state_t         wr_state_q, wr_state_d;
    logic [ID_W-1:0]   wr_id_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [LEN_W-1:0]  wr_len_q, wr_beat_q;
    logic              wr_fixed_q;
    resp_t             wr_resp_q;
    logic [15:0]       wr_lat_q;

    logic              awready_c, wready_c, bvalid_c, aw_hs, w_hs, b_hs;
    logic              w_last_beat, w_mismatch, mem_wr_en;
    logic [ID_W-1:0]   bid_c;
    resp_t             bresp_c;

    assign aw_hs       = s_axi4_if.awvalid && awready_c;
    assign w_hs        = s_axi4_if.wvalid && wready_c;
    assign b_hs        = bvalid_c && s_axi4_if.bready;
    assign w_last_beat = (wr_beat_q == wr_len_q);
    assign w_mismatch  = (s_axi4_if.wlast != w_last_beat);
    // A beat whose wlast disagrees with the count is itself suppressed.
    assign mem_wr_en   = w_hs && (wr_resp_q == OKAY) && !w_mismatch;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            wr_state_q <= W_IDLE;
        else
            wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        awready_c  = 1'b0;
        wready_c   = 1'b0;
        bvalid_c   = 1'b0;
        bid_c      = '0;
        bresp_c    = OKAY;
        case (wr_state_q)
            W_IDLE: begin
                awready_c = !Rst;
                if (aw_hs)
                    wr_state_d = W_DATA;
            end
            W_DATA: begin
                wready_c = 1'b1;
                // The beat count, not wlast, ends the data phase.
                if (w_hs && w_last_beat)
                    wr_state_d = (WR_RESP_LATENCY > 0) ? W_WAIT : W_RESP;
            end
            W_WAIT: begin
                if (wr_lat_q == WR_LAT_LAST)
                    wr_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                bid_c    = wr_id_q;
                bresp_c  = wr_resp_q;
                if (b_hs)
                    wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_id_q    <= '0;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_fixed_q <= 1'b0;
            wr_resp_q  <= OKAY;
            wr_lat_q   <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_id_q    <= s_axi4_if.awid;
                        wr_idx_q   <= aw_off[3 +: IDX_W];
                        wr_len_q   <= s_axi4_if.awlen;
                        wr_fixed_q <= (s_axi4_if.awburst == FIXED);
                        wr_resp_q  <= aw_resp_dec;
                        wr_beat_q  <= '0;
                        wr_lat_q   <= '0;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        // Keep an earlier DECERR/SLVERR; only an OKAY burst is downgraded.
                        if (w_mismatch && wr_resp_q == OKAY)
                            wr_resp_q <= SLVERR;
                        wr_beat_q <= wr_beat_q + 1'b1;
                        if (!wr_fixed_q)
                            wr_idx_q <= wr_idx_q + 1'b1;
                    end
                end
                W_WAIT: wr_lat_q <= wr_lat_q + 16'd1;
                default: ;
            endcase
        end
    end

    // ---------------- memory ----------------
    axi4_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .Clk     (Clk),
        .wr_en   (mem_wr_en),
        .wr_idx  (wr_idx_q),
        .wr_dat  (s_axi4_if.wdata),
        .wr_strb (s_axi4_if.wstrb),
        .rd_idx  (rd_idx_q),
        .rd_dat  (mem_rd_dat)
    );

`ifdef AXI4_RESP_ERR_INJECT_EN
    logic [1:0]  inj_inc;
    logic [16:0] inj_sum;
    assign inj_inc = {1'b0, ar_hs & err_inject} + {1'b0, aw_hs & err_inject};
    assign inj_sum = {1'b0, err_inject_cnt} + {15'd0, inj_inc};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            err_inject_cnt <= '0;
        else
            err_inject_cnt <= inj_sum[16] ? 16'hFFFF : inj_sum[15:0];
    end
`endif

    // ---------------- outputs ----------------
    assign s_axi4_if.arready = arready_c;
    assign s_axi4_if.rvalid  = rvalid_c;
    assign s_axi4_if.rlast   = rlast_c;
    assign s_axi4_if.rid     = rid_c;
    assign s_axi4_if.rresp   = rresp_c;
    assign s_axi4_if.rdata   = rdata_c;
    assign s_axi4_if.awready = awready_c;
    assign s_axi4_if.wready  = wready_c;
    assign s_axi4_if.bvalid  = bvalid_c;
    assign s_axi4_if.bid     = bid_c;
    assign s_axi4_if.bresp   = bresp_c;

    assign rd_done = r_hs && rlast_c;
    assign wr_done = b_hs;

endmodule
